toggle_waveform_generator: RTL and testbench
============================================

Name: toggle_waveform_generator

Overview:
Inverse of the dual-edge detector. Converts a stream of single-cycle toggle requests into a level waveform, with one level change per accepted request. Each level is held for at least MIN_HOLD cycles. Requests that arrive during a hold are queued in a saturating pending counter. The intended checker is a dual-edge detector fed from signal_o: it regenerates one pulse per toggle.

Parameters:
MIN_HOLD, 4, minimum cycles signal_o stays stable after a toggle; legal range ≥1.
MAX_PENDING, 7, maximum queued toggle requests; legal range ≥1.
PEND_W, $clog2(MAX_PENDING+1), pending counter width (derived, localparam).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous assert, active-low.
pulse_i  in  1  toggle request; each high cycle is one request.
enable_i  in  1  allows queued requests to be consumed; queuing continues while low.
clear_i  in  1  clears sticky overflow_o.
signal_o  out  1  generated level, Moore output of the state.
edge_o  out  1  high for the first cycle after each toggle.
busy_o  out  1  high when in a HOLD state or pending_o != 0.
pending_o  out  PEND_W  queued requests not yet consumed.
overflow_o  out  1  sticky; set when a request is dropped.

Behaviour:
- Reset (rst_ni=0, asynchronous): state LOW_IDLE, hold counter 0, pending_o 0, signal_o 0, edge_o 0, busy_o 0, overflow_o 0.
- Reset mid-operation discards all pending requests and any hold in progress.
- States: LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD. signal_o=1 iff state is HIGH_*.
- req = pending_q != 0 || pulse_i.
- take = enable_i && req && (state is *_IDLE || (state is *_HOLD && hold_cnt==0)).
- On take: move to the opposite-level HOLD state and load hold_cnt = MIN_HOLD-1.
- Latency: pulse_i in an IDLE cycle (pending 0, enable_i 1) makes signal_o toggle after that same clock edge.
- HOLD, hold_cnt != 0: decrement each cycle, regardless of enable_i.
- HOLD, hold_cnt == 0 and no take: go to the same-level IDLE state.
- Consecutive toggles are therefore spaced exactly MIN_HOLD cycles. With MIN_HOLD=1, signal_o can toggle every cycle.
- Pending update: pending_next = pending_q + (pulse_i accepted) - take.
  - A simultaneous pulse and take with pending 0 leaves pending at 0.
  - pulse_i is dropped when pending_q == MAX_PENDING and take == 0. That cycle sets overflow_o.
  - pulse_i with pending full and take == 1 is accepted; the count stays at MAX_PENDING.
- overflow_o: set on drop, cleared by clear_i; set wins if both occur in the same cycle.
- edge_o: registered; equals 1 in the cycle following a take, else 0.
- busy_o: combinational from registered state and pending; no glitch paths from inputs.
- enable_i low: requests accumulate up to MAX_PENDING; an ongoing hold completes, then the block parks in IDLE.

Decomposition:
- Package toggle_wave_pkg:
  - state_t enum {LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD};
  - helper function is_high(state_t).
- Sub-module sat_updown_counter (params WIDTH, MAX; inputs inc, dec; outputs count, full, drop). Holds the pending-count saturation and drop logic.
- The FSM and hold counter stay in the top module.

Test Plan (MIN_HOLD=4, MAX_PENDING=7 unless stated):
1. Hold rst_ni=0 for 3 cycles with pulse_i=1 → signal_o, edge_o, busy_o, pending_o, overflow_o all 0. Release → state LOW_IDLE, signal_o 0.
2. Single pulse_i at cycle c0 (enable_i=1) → signal_o=1 from edge c0 onward; edge_o=1 for exactly one cycle; busy_o=1 for 4 cycles; then HIGH_IDLE, busy_o 0, signal_o stays 1.
3. pulse_i high for cycles c0..c2 → pending_o sequence 0,1,2,2,1(after c4),1,1,1,0(after c8). signal_o toggles at edges c0, c4, c8 and ends 1. Exactly 3 edge_o pulses.
4. enable_i=0, 9 pulses → pending_o saturates at 7, overflow_o=1, signal_o unchanged. clear_i for one cycle → overflow_o 0. Then enable_i=1 → 7 toggles spaced 4 cycles apart; final signal_o=1.
5. Reset mid-HIGH_HOLD with pending_o=3 → all outputs 0 asynchronously, before the next clk_i edge. After release, no residual toggles.
6. Loopback: signal_o drives a dual_edge_detector_moore instance; 20 random pulses with MIN_HOLD=1 and enable_i toggling randomly → detector pulse count equals the take count; overflow_o stays 0 unless pending reached 7.

Source files
------------

// File: rtl/toggle_wave_pkg.sv
// Shared types and helpers for the toggle waveform generator.
// The state encoding keeps the output level in bit 1 and the hold flag in bit 0.
package toggle_wave_pkg;

   typedef enum logic [1:0] {
      LOW_IDLE  = 2'b00,
      LOW_HOLD  = 2'b01,
      HIGH_IDLE = 2'b10,
      HIGH_HOLD = 2'b11
   } state_t;

   function automatic logic is_high(input state_t s);
      return (s == HIGH_IDLE) || (s == HIGH_HOLD);
   endfunction

   function automatic logic is_hold(input state_t s);
      return (s == LOW_HOLD) || (s == HIGH_HOLD);
   endfunction

   function automatic state_t opposite_hold(input state_t s);
      return is_high(s) ? LOW_HOLD : HIGH_HOLD;
   endfunction

   function automatic state_t same_idle(input state_t s);
      return is_high(s) ? HIGH_IDLE : LOW_IDLE;
   endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter for queued toggle requests.
// An increment arriving while full is dropped unless a decrement frees a slot in the same cycle.
module sat_updown_counter #(
   parameter int WIDTH = 3,
   parameter int MAX   = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             full,
   output logic             drop
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             inc_ok;

   assign full   = (count_q == WIDTH'(MAX));
   assign drop   = inc && full && !dec;
   assign inc_ok = inc && !drop;
   assign count  = count_q;

   // A simultaneous accepted increment and decrement cancel out.
   always_comb begin
      count_d = count_q;
      if (inc_ok && !dec) begin
         count_d = count_q + WIDTH'(1);
      end else if (!inc_ok && dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/toggle_waveform_generator.sv
// Turns single-cycle toggle requests into a level waveform, one level change per accepted request,
// with every level held for at least MIN_HOLD cycles and early requests queued.
module toggle_waveform_generator
   import toggle_wave_pkg::*;
#(
   parameter int MIN_HOLD    = 4,
   parameter int MAX_PENDING = 7,
   localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              pulse_i,
   input  logic              enable_i,
   input  logic              clear_i,
   output logic              signal_o,
   output logic              edge_o,
   output logic              busy_o,
   output logic [PEND_W-1:0] pending_o,
   output logic              overflow_o
);

   localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

   state_t              state_q;
   state_t              state_d;
   logic [HOLD_W-1:0]   hold_q;
   logic [HOLD_W-1:0]   hold_d;
   logic                edge_q;
   logic                overflow_q;
   logic [PEND_W-1:0]   pending_q;
   logic                pending_full;
   logic                pulse_drop;
   logic                pending_any;
   logic                req;
   logic                hold_done;
   logic                take;

   sat_updown_counter #(
      .WIDTH (PEND_W),
      .MAX   (MAX_PENDING)
   ) u_pending (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (pulse_i),
      .dec   (take),
      .count (pending_q),
      .full  (pending_full),
      .drop  (pulse_drop)
   );

   assign pending_any = pending_full || (pending_q != '0);
   assign req         = pending_any || pulse_i;
   assign hold_done   = !is_hold(state_q) || (hold_q == '0);
   assign take        = enable_i && req && hold_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LOW_IDLE;
         hold_q  <= '0;
         edge_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         edge_q  <= take;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else if (pulse_drop) begin
         overflow_q <= 1'b1;
      end else if (clear_i) begin
         overflow_q <= 1'b0;
      end
   end

   // The hold countdown runs regardless of enable_i; only the next toggle waits for it.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (take) begin
         state_d = opposite_hold(state_q);
         hold_d  = HOLD_LOAD;
      end else if (is_hold(state_q)) begin
         if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
         end else begin
            state_d = same_idle(state_q);
         end
      end
   end

   always_comb begin
      signal_o   = is_high(state_q);
      edge_o     = edge_q;
      busy_o     = is_hold(state_q) || pending_any;
      pending_o  = pending_q;
      overflow_o = overflow_q;
   end

endmodule

// File: tb/tb_toggle_waveform_generator.sv
// Bench for toggle_waveform_generator: two instances (MIN_HOLD 4 and 1) share stimulus and are
// compared every cycle against a cycle-count based reference model.
module tb_toggle_waveform_generator;

   localparam int MAXP = 7;
   localparam int PW   = $clog2(MAXP + 1);
   localparam int FAR  = 1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pulse = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;

   logic          sig4, edge4, busy4, ovf4;
   logic [PW-1:0] pend4;
   logic          sig1, edge1, busy1, ovf1;
   logic [PW-1:0] pend1;

   always #5 clk = ~clk;

   toggle_waveform_generator #(.MIN_HOLD(4), .MAX_PENDING(MAXP)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .pulse_i(pulse), .enable_i(en), .clear_i(clr),
      .signal_o(sig4), .edge_o(edge4), .busy_o(busy4), .pending_o(pend4), .overflow_o(ovf4)
   );

   toggle_waveform_generator #(.MIN_HOLD(1), .MAX_PENDING(MAXP)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .pulse_i(pulse), .enable_i(en), .clear_i(clr),
      .signal_o(sig1), .edge_o(edge1), .busy_o(busy1), .pending_o(pend1), .overflow_o(ovf1)
   );

   int tests = 0;
   int failed = 0;

   // Model: gap = cycles since the last accepted toggle; a toggle is allowed once gap >= hold.
   int hold_of [2] = '{4, 1};
   int m_gap   [2];
   int m_pend  [2];
   int m_takes [2];
   int det_cnt [2];
   bit m_level [2];
   bit m_edge  [2];
   bit m_ovf   [2];
   bit prev_sig[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_gap[k]    = FAR;
         m_pend[k]   = 0;
         m_level[k]  = 1'b0;
         m_edge[k]   = 1'b0;
         m_ovf[k]    = 1'b0;
      end
   endtask

   task automatic model_step(input bit p, input bit e, input bit c);
      for (int k = 0; k < 2; k++) begin
         bit req;
         bit take;
         bit drop;
         req  = (m_pend[k] != 0) || p;
         take = e && req && (m_gap[k] >= hold_of[k]);
         drop = p && (m_pend[k] == MAXP) && !take;
         m_pend[k] = m_pend[k] + ((p && !drop) ? 1 : 0) - (take ? 1 : 0);
         if (drop) m_ovf[k] = 1'b1;
         else if (c) m_ovf[k] = 1'b0;
         m_edge[k] = take;
         if (take) begin
            m_level[k] = ~m_level[k];
            m_gap[k]   = 1;
            m_takes[k]++;
         end else if (m_gap[k] < FAR) begin
            m_gap[k]++;
         end
      end
   endtask

   task automatic check_output(input string phase);
      for (int k = 0; k < 2; k++) begin
         logic          s, ed, b, o;
         logic [PW-1:0] pn;
         bit            exp_busy;
         s  = (k == 0) ? sig4  : sig1;
         ed = (k == 0) ? edge4 : edge1;
         b  = (k == 0) ? busy4 : busy1;
         o  = (k == 0) ? ovf4  : ovf1;
         pn = (k == 0) ? pend4 : pend1;
         exp_busy = (m_gap[k] <= hold_of[k]) || (m_pend[k] != 0);
         check($sformatf("%s/h%0d/signal", phase, hold_of[k]), 32'(s), 32'(m_level[k]));
         check($sformatf("%s/h%0d/edge", phase, hold_of[k]), 32'(ed), 32'(m_edge[k]));
         check($sformatf("%s/h%0d/busy", phase, hold_of[k]), 32'(b), 32'(exp_busy));
         check($sformatf("%s/h%0d/pending", phase, hold_of[k]), 32'(pn), 32'(m_pend[k]));
         check($sformatf("%s/h%0d/overflow", phase, hold_of[k]), 32'(o), 32'(m_ovf[k]));
         if (s !== prev_sig[k]) det_cnt[k]++;
         prev_sig[k] = s;
      end
   endtask

   task automatic apply_stimulus(input string phase, input bit p, input bit e, input bit c);
      @(negedge clk);
      pulse = p;
      en    = e;
      clr   = c;
      model_step(p, e, c);
      @(posedge clk);
      #1;
      check_output(phase);
   endtask

   initial begin
      $display("[TB] start");
      for (int k = 0; k < 2; k++) begin
         m_takes[k]  = 0;
         det_cnt[k]  = 0;
         prev_sig[k] = 1'b0;
      end
      model_reset();

      // Reset held for three cycles with pulse_i high.
      @(negedge clk);
      rst_n = 1'b0;
      pulse = 1'b1;
      en    = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_output("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulse = 1'b0;
      apply_stimulus("idle", 1'b0, 1'b1, 1'b0);

      // Single request, then let the hold expire.
      apply_stimulus("single", 1'b1, 1'b1, 1'b0);
      check("single/immediate_toggle", 32'(sig4), 32'd1);
      repeat (6) apply_stimulus("single", 1'b0, 1'b1, 1'b0);

      // Three back-to-back requests queue behind the hold.
      repeat (3) apply_stimulus("burst", 1'b1, 1'b1, 1'b0);
      check("burst/pending_after_3", 32'(pend4), 32'd2);
      repeat (12) apply_stimulus("burst", 1'b0, 1'b1, 1'b0);

      // Saturation with enable low, clear, then drain.
      repeat (9) apply_stimulus("saturate", 1'b1, 1'b0, 1'b0);
      check("saturate/pending_full", 32'(pend4), 32'd7);
      check("saturate/overflow_set", 32'(ovf4), 32'd1);
      apply_stimulus("clear", 1'b0, 1'b0, 1'b1);
      check("clear/overflow_cleared", 32'(ovf4), 32'd0);
      repeat (34) apply_stimulus("drain", 1'b0, 1'b1, 1'b0);
      check("drain/final_level", 32'(sig4), 32'd1);

      // Build HIGH_HOLD with three queued requests, then reset asynchronously.
      apply_stimulus("prep", 1'b1, 1'b1, 1'b0);
      repeat (5) apply_stimulus("prep", 1'b0, 1'b1, 1'b0);
      repeat (4) apply_stimulus("prep", 1'b1, 1'b1, 1'b0);
      check("prep/pending3", 32'(pend4), 32'd3);
      check("prep/high", 32'(sig4), 32'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_output("async_reset");
      @(negedge clk);
      pulse = 1'b0;
      @(posedge clk);
      #1;
      check_output("async_reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) apply_stimulus("post_reset", 1'b0, 1'b1, 1'b0);

      // Randomized traffic; the toggle count seen on signal_o must match the accepted requests.
      for (int k = 0; k < 2; k++) begin
         m_takes[k] = 0;
         det_cnt[k] = 0;
      end
      for (int i = 0; i < 150; i++) begin
         apply_stimulus("random",
                        $urandom_range(0, 3) == 0,
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, 15) == 0);
      end
      repeat (40) apply_stimulus("random_drain", 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("loopback/h%0d/toggles", hold_of[k]), 32'(det_cnt[k]), 32'(m_takes[k]));
      end
      check("loopback/h4/empty", 32'(pend4), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
